// File: rtl/div_pkg.sv
// Shared definitions for the divider front end: FSM encoding and bench-facing latency.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_OUT   = 3'd4
  } div_state_t;

  localparam int DIV_DATA_W  = 32;
  localparam int DIV_LATENCY = DIV_DATA_W + 5;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, modulo 2^DATA_W.
module div_sign_fix #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic              neg,
  output logic [DATA_W-1:0] y
);

  assign y = neg ? (~a + {{(DATA_W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/div_frontend.sv
// Valid/ready front end for the sequential subtract-shift divider core.
// Optional signed path enabled by defining DIV_SIGNED_EN.
module div_frontend
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic              out_div_zero,
  output logic              div_start,
  input  logic              div_done,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder
);

  div_state_t        state;
  logic              rdy_en;
  logic              accept;
  logic              neg_q;
  logic              neg_r;
  logic [DATA_W-1:0] mag_dividend;
  logic [DATA_W-1:0] mag_divisor;
  logic [DATA_W-1:0] q_raw;
  logic [DATA_W-1:0] r_raw;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  // rdy_en keeps in_ready low through reset even though the FSM rests in IDLE
  assign in_ready = rdy_en && (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef DIV_SIGNED_EN
  logic sign_a;
  logic sign_b;

  assign sign_a = in_signed & in_dividend[DATA_W-1];
  assign sign_b = in_signed & in_divisor[DATA_W-1];

  div_sign_fix #(.DATA_W(DATA_W)) u_mag_dividend (.a(in_dividend), .neg(sign_a), .y(mag_dividend));
  div_sign_fix #(.DATA_W(DATA_W)) u_mag_divisor  (.a(in_divisor),  .neg(sign_b), .y(mag_divisor));
  div_sign_fix #(.DATA_W(DATA_W)) u_fix_q        (.a(q_raw),       .neg(neg_q),  .y(q_fix));
  div_sign_fix #(.DATA_W(DATA_W)) u_fix_r        (.a(r_raw),       .neg(neg_r),  .y(r_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
    end
  end
`else
  logic unused_in_signed;

  assign unused_in_signed = in_signed;
  assign mag_dividend     = in_dividend;
  assign mag_divisor      = in_divisor;
  assign neg_q            = 1'b0;
  assign neg_r            = 1'b0;
  assign q_fix            = q_raw;
  assign r_fix            = r_raw;
`endif

  // core result capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == ST_WAIT && div_done) begin
      q_raw <= div_quotient;
      r_raw <= div_remainder;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rdy_en        <= 1'b0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            div_dividend <= mag_dividend;
            div_divisor  <= mag_divisor;
            if (in_divisor == '0) begin
              out_quotient  <= '1;
              out_remainder <= in_dividend;
              out_div_zero  <= 1'b1;
              out_valid     <= 1'b1;
              state         <= ST_OUT;
            end else begin
              // launch the start pulse right away when the core is already idle
              div_start <= !div_done;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (div_start) begin
            div_start <= 1'b0;
            state     <= ST_WAIT;
          end else if (!div_done) begin
            div_start <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (div_done) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          out_quotient  <= q_fix;
          out_remainder <= r_fix;
          out_div_zero  <= 1'b0;
          out_valid     <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          div_start <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_frontend.sv
// Directed bench for div_frontend with a behavioural divider core attached.
module tb_div_frontend;
  import div_pkg::*;

  localparam int DW = 32;

`ifdef DIV_SIGNED_EN
  localparam logic [31:0] EXP_NEG100_Q = 32'hFFFF_FFF2;
  localparam logic [31:0] EXP_NEG100_R = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_NEG7_Q   = 32'hFFFF_FFF2;
  localparam logic [31:0] EXP_NEG7_R   = 32'h0000_0002;
  localparam logic [31:0] EXP_MIN_Q    = 32'h8000_0000;
  localparam logic [31:0] EXP_MIN_R    = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG100_Q = 32'h2492_4916;
  localparam logic [31:0] EXP_NEG100_R = 32'h0000_0002;
  localparam logic [31:0] EXP_NEG7_Q   = 32'h0000_0000;
  localparam logic [31:0] EXP_NEG7_R   = 32'h0000_0064;
  localparam logic [31:0] EXP_MIN_Q    = 32'h0000_0000;
  localparam logic [31:0] EXP_MIN_R    = 32'h8000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic [DW-1:0] out_remainder;
  logic          out_div_zero;
  logic          div_start;
  logic          div_done;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;

  always #5 clk = ~clk;

  div_frontend #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_div_zero(out_div_zero),
    .div_start(div_start), .div_done(div_done),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Core model: done high out of reset for a few cycles, result DATA_W+2 cycles after start,
  // done then held for one idle cycle before dropping.
  logic          core_busy;
  logic          core_pend;
  int            core_cnt;
  int            core_hold;
  logic [DW-1:0] core_a;
  logic [DW-1:0] core_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_done      <= 1'b1;
      core_hold     <= 3;
      core_busy     <= 1'b0;
      core_pend     <= 1'b0;
      core_cnt      <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      core_busy <= 1'b1;
      core_pend <= 1'b1;
      core_cnt  <= 0;
      div_done  <= 1'b0;
    end else if (core_busy) begin
      if (core_pend) begin
        core_a    <= div_dividend;
        core_b    <= div_divisor;
        core_pend <= 1'b0;
      end
      core_cnt <= core_cnt + 1;
      if (core_cnt == DW) begin
        core_busy     <= 1'b0;
        div_done      <= 1'b1;
        core_hold     <= 1;
        div_quotient  <= core_a / core_b;
        div_remainder <= core_a % core_b;
      end
    end else if (div_done) begin
      if (core_hold == 0) div_done <= 1'b0;
      else core_hold <= core_hold - 1;
    end
  end

  int start_cnt = 0;
  int start_while_done = 0;
  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;
  always @(negedge clk) if (div_start && div_done) start_while_done <= start_while_done + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat, output int starts);
    int guard;
    int s0;
    logic stable;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, " in_ready"}, in_ready, 1);
    in_dividend = a;
    in_divisor  = b;
    in_signed   = s;
    in_valid    = 1'b1;
    s0 = start_cnt;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, " out_valid"}, out_valid, 1);
    q = out_quotient;
    r = out_remainder;
    dz = out_div_zero;
    starts = start_cnt - s0;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (out_quotient !== q || out_remainder !== r || out_div_zero !== dz ||
            !out_valid || in_ready) stable = 1'b0;
      end
      check_val({tag, " hold stable"}, stable, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [31:0] q, r;
  logic        dz;
  int          lat, starts;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst in_ready", in_ready, 0);
    check_val("rst out_valid", out_valid, 0);
    check_val("rst div_start", div_start, 0);
    check_val("rst out_q_r_dz", {out_quotient, out_remainder[30:0], out_div_zero}, 64'd0);
    check_val("rst div_operands", {div_dividend, div_divisor}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("post-rst in_ready", in_ready, 1);

    // core still reports done: issue must wait; also hold the result 10 cycles
    run_div("early 50/6", 32'd50, 32'd6, 1'b0, 10, q, r, dz, lat, starts);
    check_val("early q", q, 32'd8);
    check_val("early r", r, 32'd2);
    check_val("early delayed", lat > DIV_LATENCY, 1);
    check_val("early starts", starts, 1);

    run_div("u 100/7", 32'd100, 32'd7, 1'b0, 0, q, r, dz, lat, starts);
    check_val("u100/7 q", q, 32'd14);
    check_val("u100/7 r", r, 32'd2);
    check_val("u100/7 dz", dz, 0);
    check_val("u100/7 latency", lat, DIV_LATENCY);
    check_val("u100/7 starts", starts, 1);

    run_div("s -100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, q, r, dz, lat, starts);
    check_val("s-100/7 q", q, EXP_NEG100_Q);
    check_val("s-100/7 r", r, EXP_NEG100_R);
    check_val("s-100/7 latency", lat, DIV_LATENCY);

    run_div("s 100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0, q, r, dz, lat, starts);
    check_val("s100/-7 q", q, EXP_NEG7_Q);
    check_val("s100/-7 r", r, EXP_NEG7_R);

    run_div("zero", 32'h0000_1234, 32'd0, 1'b0, 0, q, r, dz, lat, starts);
    check_val("zero q", q, 32'hFFFF_FFFF);
    check_val("zero r", r, 32'h0000_1234);
    check_val("zero dz", dz, 1);
    check_val("zero latency", lat, 1);
    check_val("zero starts", starts, 0);

    run_div("szero", 32'hFFFF_FFFB, 32'd0, 1'b1, 0, q, r, dz, lat, starts);
    check_val("szero q", q, 32'hFFFF_FFFF);
    check_val("szero r", r, 32'hFFFF_FFFB);
    check_val("szero dz", dz, 1);

    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, q, r, dz, lat, starts);
    check_val("min/-1 q", q, EXP_MIN_Q);
    check_val("min/-1 r", r, EXP_MIN_R);
    check_val("min/-1 dz", dz, 0);

    // reset while the core is busy
    @(negedge clk);
    in_dividend = 32'd1000;
    in_divisor  = 32'd3;
    in_signed   = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst out_valid", out_valid, 0);
    check_val("midrst in_ready", in_ready, 0);
    check_val("midrst div_start", div_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("midrst in_ready after", in_ready, 1);
    run_div("after rst 9/3", 32'd9, 32'd3, 1'b0, 0, q, r, dz, lat, starts);
    check_val("9/3 q", q, 32'd3);
    check_val("9/3 r", r, 32'd0);
    check_val("9/3 starts", starts, 1);

    check_val("start while done", start_while_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
